// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// Optional macro SERIAL_ADD_OVF_EN adds the signed overflow flag.
interface serial_adder_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             overflow;
`endif

  // Producer/consumer side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry, busy
`ifdef SERIAL_ADD_OVF_EN
    , input overflow
`endif
  );

  // Controller side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry, busy
`ifdef SERIAL_ADD_OVF_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder: two half adders plus an OR for carry.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  half_adder u_ha1 (
    .a_i (s1),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign c_o = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// 1-bit half adder primitive.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts two WIDTH-bit operands, adds them
// LSB-first through one shared full-adder cell (one bit per clock) and
// returns sum/carry through a valid/ready handshake.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-2:0]   sum_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               c_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q;
`endif

  logic               fa_s;
  logic               fa_c;
  logic [WIDTH-1:0]   sum_d;

  // The single shared adder cell works on the current LSBs and the carry flop
  fa_cell u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Partial sum with this cycle's bit entering from the MSB side
  assign sum_d = {fa_s, sum_sh_q};

  // Sequencer: accept, shift one bit per cycle, present result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh_q     <= bus.a;
            b_sh_q     <= bus.b;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_d[WIDTH-1:1];
          c_q      <= fa_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            sum_q       <= sum_d;
            carry_q     <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
            // carry into the MSB is still in c_q on the final bit
            ovf_q       <= c_q ^ fa_c;
`endif
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.busy      = busy_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 plus a WIDTH=2 sweep).
// Honours SERIAL_ADD_OVF_EN when defined.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Accept one operand pair: called #1 after an edge while in IDLE
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    bus8.a = av;
    bus8.b = bv;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  // Count edges until out_valid is visible (bounded)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!bus8.out_valid) begin
      errors++;
      $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", bus8.out_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
    checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", bus8.sum); end
    checks++; if (bus8.carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus8.carry); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus8.busy); end
    checks++; if ({bus2.in_ready, bus2.out_valid} !== 2'b10) begin errors++; $display("FAIL reset_w2_hs: got %b want 10", {bus2.in_ready, bus2.out_valid}); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (bus8.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus8.overflow); end
`endif
  endtask

  // 0x0F+0x01; out_valid rises on the 8th edge after accept, taken on the 9th
  task automatic test_basic();
    int lat;
    bus8.out_ready = 1'b1;
    start_op(8'h0F, 8'h01);
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_run: got %b want 0", bus8.in_ready); end
    checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_run: got %b want 1", bus8.busy); end
    wait_valid(lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++; if (bus8.sum !== 8'h10) begin errors++; $display("FAIL basic_sum: got %h want 10", bus8.sum); end
    checks++; if (bus8.carry !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b want 0", bus8.carry); end
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL basic_excl: in_ready got %b want 0", bus8.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL basic_ov_clear: got %b want 0", bus8.out_valid); end
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_back: got %b want 1", bus8.in_ready); end
  endtask

  task automatic test_carry();
    int lat;
    bus8.out_ready = 1'b1;
    start_op(8'hFF, 8'h01);
    wait_valid(lat);
    checks++; if ({bus8.carry, bus8.sum} !== 9'h100) begin errors++; $display("FAIL carry_ff01: got %h want 100", {bus8.carry, bus8.sum}); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (bus8.overflow !== 1'b0) begin errors++; $display("FAIL ovf_ff01: got %b want 0", bus8.overflow); end
`endif
    @(posedge clk); #1;
    start_op(8'h7F, 8'h01);
    wait_valid(lat);
    checks++; if ({bus8.carry, bus8.sum} !== 9'h080) begin errors++; $display("FAIL carry_7f01: got %h want 080", {bus8.carry, bus8.sum}); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (bus8.overflow !== 1'b1) begin errors++; $display("FAIL ovf_7f01: got %b want 1", bus8.overflow); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus8.out_ready = 1'b0;
    start_op(8'hA5, 8'h5A);
    wait_valid(lat);
    checks++; if ({bus8.carry, bus8.sum} !== 9'h0FF) begin errors++; $display("FAIL bp_result: got %h want 0ff", {bus8.carry, bus8.sum}); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus8.out_valid); end
      checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, bus8.in_ready); end
      checks++; if ({bus8.carry, bus8.sum} !== 9'h0FF) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want 0ff", i, {bus8.carry, bus8.sum}); end
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus8.in_ready, bus8.out_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got %b want 10", {bus8.in_ready, bus8.out_valid}); end
  endtask

  // A second in_valid during RUN must not disturb the first operation
  task automatic test_busy_reject();
    int lat;
    bus8.out_ready = 1'b1;
    start_op(8'h22, 8'h11);
    @(posedge clk); #1;
    bus8.a = 8'h01;
    bus8.b = 8'h01;
    bus8.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL reject_latency: got %0d want 4", lat); end
    checks++; if ({bus8.carry, bus8.sum} !== 9'h033) begin errors++; $display("FAIL reject_result: got %h want 033", {bus8.carry, bus8.sum}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({bus8.in_ready, bus8.out_valid, bus8.busy} !== 3'b100) begin errors++; $display("FAIL reject_idle: got %b want 100", {bus8.in_ready, bus8.out_valid, bus8.busy}); end
  endtask

  task automatic test_abort();
    int lat;
    bus8.out_ready = 1'b1;
    start_op(8'hF0, 8'h0F);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({bus8.in_ready, bus8.out_valid, bus8.busy} !== 3'b100) begin errors++; $display("FAIL abort_hs: got %b want 100", {bus8.in_ready, bus8.out_valid, bus8.busy}); end
    checks++; if ({bus8.carry, bus8.sum} !== 9'h000) begin errors++; $display("FAIL abort_data: got %h want 000", {bus8.carry, bus8.sum}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_op(8'h03, 8'h04);
    wait_valid(lat);
    checks++; if ({bus8.carry, bus8.sum} !== 9'h007) begin errors++; $display("FAIL abort_next: got %h want 007", {bus8.carry, bus8.sum}); end
    @(posedge clk); #1;
  endtask

  // Exhaustive WIDTH=2 sweep against integer arithmetic
  task automatic test_w2_sweep();
    int lat;
    int s;
    int sa;
    int sb;
    logic [2:0] exp3;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        bus2.a = 2'(i);
        bus2.b = 2'(j);
        bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        lat = 0;
        while (!bus2.out_valid && lat < 20) begin
          @(posedge clk); #1;
          lat++;
        end
        s = i + j;
        exp3 = 3'(s);
        checks++; if (!bus2.out_valid || lat != 2 || {bus2.carry, bus2.sum} !== exp3) begin
          errors++;
          $display("FAIL w2_%0d_%0d: got valid=%b lat=%0d res=%b want lat=2 res=%b", i, j, bus2.out_valid, lat, {bus2.carry, bus2.sum}, exp3);
        end
`ifdef SERIAL_ADD_OVF_EN
        sa = (i >= 2) ? i - 4 : i;
        sb = (j >= 2) ? j - 4 : j;
        checks++; if (bus2.overflow !== ((sa + sb > 1) || (sa + sb < -2))) begin
          errors++;
          $display("FAIL w2_ovf_%0d_%0d: got %b want %b", i, j, bus2.overflow, ((sa + sb > 1) || (sa + sb < -2)));
        end
`else
        sa = 0;
        sb = sa;
`endif
        @(posedge clk); #1;
      end
    end
  endtask

  // in_valid held high: accepts are WIDTH+2 cycles apart with out_ready high
  task automatic test_back_to_back();
    int acc_cyc[2];
    logic [8:0] res[2];
    int nacc;
    int nres;
    acc_cyc = '{0, 0};
    res = '{9'h000, 9'h000};
    nacc = 0;
    nres = 0;
    bus8.out_ready = 1'b1;
    bus8.a = 8'h10;
    bus8.b = 8'h20;
    bus8.in_valid = 1'b1;
    for (int k = 0; k < 40 && nres < 2; k++) begin
      if (bus8.out_valid) begin
        res[nres] = {bus8.carry, bus8.sum};
        nres++;
      end
      if (bus8.in_ready && bus8.in_valid && nacc < 2) begin
        acc_cyc[nacc] = k;
        nacc++;
      end
      @(posedge clk); #1;
      if (nacc == 1) begin
        bus8.a = 8'h30;
        bus8.b = 8'h40;
      end
      if (nacc == 2) bus8.in_valid = 1'b0;
    end
    bus8.in_valid = 1'b0;
    checks++; if (nacc != 2 || acc_cyc[1] - acc_cyc[0] != 10) begin errors++; $display("FAIL b2b_period: got accepts=%0d gap=%0d want 2 and 10", nacc, acc_cyc[1] - acc_cyc[0]); end
    checks++; if (res[0] !== 9'h030) begin errors++; $display("FAIL b2b_res0: got %h want 030", res[0]); end
    checks++; if (res[1] !== 9'h070) begin errors++; $display("FAIL b2b_res1: got %h want 070", res[1]); end
  endtask

  initial begin
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.a         = '0;
    bus2.b         = '0;
    bus2.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_busy_reject();
    test_abort();
    test_w2_sweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
